// File: rtl/mem_ctrl_arbiter.sv
// mem_ctrl_arbiter: arbitrates IF fetches and MEM loads/stores onto a byte-wide RAM bus.
// Optional macro MEMCTRL_IO_STALL_EN adds io_buffer_full back-pressure on IO-space stores.
module mem_ctrl_arbiter #(
  parameter int ADDR_W = 32,
  parameter int IF_BYTES = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_clear,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              read_mem,
  input  logic              write_mem,
  input  logic [ADDR_W-1:0] mem_addr_to_read,
  input  logic [31:0]       mem_data_to_write,
  input  logic [2:0]        data_len,
  output logic              mem_load_done,
  output logic [31:0]       mem_ctrl_read_in,
  output logic [1:0]        mem_ctrl_busy_state
`ifdef MEMCTRL_IO_STALL_EN
  ,
  input  logic              io_buffer_full
`endif
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t r_state, w_state;
  logic [ADDR_W-1:0] r_base, w_base, w_a, w_wbase, w_waddr, w_raddr;
  logic [2:0] r_n, w_n, r_cnt, w_cnt, w_wcnt, w_wn;
  logic [31:0] r_wdata, w_wdata, r_buf, w_buf, w_wsrc, w_capt, w_if_data, w_read_in;
  logic [7:0] w_dout;
  logic [1:0] w_busy;
  logic w_wr, w_if_done, w_load_done, w_idle_wr, w_idle_rd, w_idle_if, w_stall;
  assign w_idle_wr = r_state == IDLE && write_mem;
  assign w_idle_rd = r_state == IDLE && !write_mem && read_mem;
  assign w_idle_if = r_state == IDLE && !write_mem && !read_mem && if_req;
  // Store byte 0 is issued at the acceptance edge, so the write path looks through to the inputs in IDLE.
  assign w_wbase = w_idle_wr ? mem_addr_to_read : r_base;
  assign w_wsrc = w_idle_wr ? mem_data_to_write : r_wdata;
  assign w_wcnt = w_idle_wr ? 3'd0 : r_cnt;
  assign w_wn = w_idle_wr ? data_len + 3'd1 : r_n;
  assign w_waddr = w_wbase + ADDR_W'(w_wcnt);
  assign w_raddr = r_base + ADDR_W'(r_cnt + 3'd1);
  assign w_capt = r_buf | ({24'd0, mem_din} << {r_cnt - 3'd1, 3'b000});
`ifdef MEMCTRL_IO_STALL_EN
  assign w_stall = io_buffer_full && w_waddr[17:16] == 2'b11;
`else
  assign w_stall = 1'b0;
`endif
  always_comb begin
    w_state = r_state;
    w_base = r_base;
    w_n = r_n;
    w_cnt = r_cnt;
    w_wdata = r_wdata;
    w_buf = r_buf;
    w_a = mem_a;
    w_dout = mem_dout;
    w_wr = mem_wr;
    w_busy = mem_ctrl_busy_state;
    w_if_done = 1'b0;
    w_load_done = 1'b0;
    w_if_data = if_data;
    w_read_in = mem_ctrl_read_in;
    if (w_idle_wr || r_state == WRITE) begin
      w_state = WRITE;
      w_busy = 2'b10;
      w_base = w_wbase;
      w_n = w_wn;
      w_wdata = w_wsrc;
      w_wr = 1'b0;
      if (w_wcnt == w_wn) begin
        w_state = IDLE;
        w_busy = 2'b00;
        w_load_done = 1'b1;
      end else if (!w_stall) begin
        w_a = w_waddr;
        w_dout = w_wsrc[{w_wcnt[1:0], 3'b000} +: 8];
        w_wr = 1'b1;
        w_cnt = w_wcnt + 3'd1;
      end
    end else if (w_idle_rd || w_idle_if) begin
      w_state = READ;
      w_busy = w_idle_rd ? 2'b10 : 2'b01;
      w_base = w_idle_rd ? mem_addr_to_read : if_addr;
      w_n = w_idle_rd ? data_len : 3'(IF_BYTES);
      w_cnt = 3'd0;
      w_buf = '0;
      w_a = w_base;
      w_wr = 1'b0;
    end else if (r_state == READ) begin
      // RAM data lags its address by one cycle, so byte cnt-1 is captured while address cnt is out.
      if (if_clear && mem_ctrl_busy_state[0]) begin
        w_state = IDLE;
        w_busy = 2'b00;
      end else if (r_cnt == r_n) begin
        w_state = IDLE;
        w_busy = 2'b00;
        w_if_done = mem_ctrl_busy_state[0];
        w_load_done = mem_ctrl_busy_state[1];
        w_if_data = mem_ctrl_busy_state[0] ? w_capt : if_data;
        w_read_in = mem_ctrl_busy_state[1] ? w_capt : mem_ctrl_read_in;
      end else begin
        w_cnt = r_cnt + 3'd1;
        w_a = r_cnt + 3'd1 < r_n ? w_raddr : mem_a;
        w_buf = r_cnt != 3'd0 ? w_capt : r_buf;
      end
    end
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_base <= '0;
      r_n <= '0;
      r_cnt <= '0;
      r_wdata <= '0;
      r_buf <= '0;
      mem_a <= '0;
      mem_dout <= '0;
      mem_wr <= 1'b0;
      mem_ctrl_busy_state <= '0;
      if_done <= 1'b0;
      mem_load_done <= 1'b0;
      if_data <= '0;
      mem_ctrl_read_in <= '0;
    end else if (rdy_in) begin
      r_state <= w_state;
      r_base <= w_base;
      r_n <= w_n;
      r_cnt <= w_cnt;
      r_wdata <= w_wdata;
      r_buf <= w_buf;
      mem_a <= w_a;
      mem_dout <= w_dout;
      mem_wr <= w_wr;
      mem_ctrl_busy_state <= w_busy;
      if_done <= w_if_done;
      mem_load_done <= w_load_done;
      if_data <= w_if_data;
      mem_ctrl_read_in <= w_read_in;
    end
  end
  assert property (@(posedge clk_in) disable iff (rst_in)
    (w_idle_wr && rdy_in) |-> data_len inside {3'd0, 3'd1, 3'd3});
  assert property (@(posedge clk_in) disable iff (rst_in)
    (w_idle_rd && rdy_in) |-> data_len inside {3'd1, 3'd2, 3'd4});
endmodule

// File: doc/mem_ctrl_arbiter.md
Name: mem_ctrl_arbiter

Overview:
- Responder side of the load/store request interface driven by the MEM stage, plus an instruction-fetch port for IF.
- Arbitrates the two requesters onto the single byte-wide synchronous RAM/IO bus.
- Serialises multi-byte transfers into byte cycles, reassembles read data little-endian and returns it with a one-cycle done pulse.
- Sits between the pipeline (IF, MEM) and the top-level RAM ports.

Parameters:
- ADDR_W, 32, width of all byte addresses.
- IF_BYTES, 4, bytes fetched per IF request.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  global ready; when 0 all state and outputs hold.
- mem_din  input  8  RAM read byte, valid one cycle after its address.
- mem_dout  output  8  RAM write byte.
- mem_a  output  ADDR_W  RAM byte address.
- mem_wr  output  1  RAM write strobe.
- if_req  input  1  IF fetch request, held until if_done.
- if_addr  input  ADDR_W  fetch address.
- if_clear  input  1  abort an in-flight IF fetch.
- if_done  output  1  one-cycle fetch complete.
- if_data  output  32  fetched word, valid with if_done.
- read_mem  input  1  MEM load request.
- write_mem  input  1  MEM store request.
- mem_addr_to_read  input  ADDR_W  load/store address.
- mem_data_to_write  input  32  store data, low bytes used.
- data_len  input  3  loads: byte count (1/2/4); stores: byte count minus 1 (0/1/3).
- mem_load_done  output  1  one-cycle load/store complete.
- mem_ctrl_read_in  output  32  load data, zero-extended, valid with mem_load_done.
- mem_ctrl_busy_state  output  2  bit1 = serving MEM, bit0 = serving IF.

Behaviour:
- Reset (async): state IDLE; mem_a, mem_dout, mem_wr, if_done, if_data, mem_load_done, mem_ctrl_read_in, busy_state and all counters = 0. Reset mid-transfer drops it with no done pulse; mem_wr falls immediately.
- States:
  - IDLE: requests sampled at a clock edge E0.
  - READ: IF fetches and MEM loads.
  - WRITE: MEM stores.
- Priority in IDLE: write_mem > read_mem > if_req. IF waits while MEM is served.
- Acceptance at E0: latch address, byte count n (load n = data_len; store n = data_len+1; IF n = IF_BYTES) and store data. Set busy_state to 2'b10 (MEM) or 2'b01 (IF).
- READ:
  - Byte k address (base+k) is driven on mem_a in the cycle after edge E0+k, with mem_wr=0.
  - mem_din for byte k is captured into bits [8k+7:8k] at edge E0+k+2.
  - Done is high in the cycle after E0+n+1.
  - Unused upper bytes read as 0.
- WRITE:
  - Byte k of the store data goes on mem_dout, with mem_wr=1 and mem_a=base+k, in the cycle after E0+k.
  - mem_load_done is high in the cycle after E0+n.
  - mem_wr returns to 0 in the done cycle.
- Done cycle: busy_state=0 and state=IDLE. A new request sampled at the end of the done cycle is accepted; there is no idle bubble beyond that.
- Requests are not re-sampled while busy. MEM deasserting read_mem/write_mem after busy_state[1]=1 is expected and ignored.
- if_clear while serving IF: abort at that edge, return to IDLE, no if_done. if_clear is ignored while serving MEM or in IDLE.
- rdy_in=0: freeze counters, state and outputs. A byte already presented to RAM is recaptured correctly after resume because the address is held.
- Address wrap: base+k is computed modulo 2^ADDR_W.
- Illegal data_len (load 0/3/5-7, store 2/4-7): checker assertion; behaviour unspecified.

Optional Feature:
- Macro MEMCTRL_IO_STALL_EN.
- Defined: adds input io_buffer_full (1 bit). A store byte whose address has bits [17:16]==2'b11 is not issued while io_buffer_full=1: mem_wr=0 and the counter holds. Issue resumes the cycle after io_buffer_full falls.
- Undefined: port absent; IO stores proceed at full rate.

Test Plan:
- RAM[0x100..0x103]=11,22,33,44; read_mem=1, addr 0x100, data_len=4 -> busy_state=2'b10 after E0; mem_a 0x100..0x103 in consecutive cycles; mem_load_done=1 with mem_ctrl_read_in=0x44332211 in cycle after E0+5.
- write_mem=1, addr 0x200, data 0xAABBCCDD, data_len=1 -> mem_wr=1 with (0x200,DD) then (0x201,CC); done in cycle after E0+2; RAM[0x202] unchanged.
- if_req addr 0x0 and read_mem addr 0x10 len 1 asserted same cycle -> MEM served first (done after E0+2, read_in zero-extended byte); IF accepted at the done-cycle edge, if_data=word at 0x0.
- IF fetch in progress, if_clear=1 after byte 1 captured -> no if_done, state IDLE next cycle, new if_req at 0x40 completes normally.
- rst_in pulsed mid-store after byte 0 -> mem_wr=0 immediately, all outputs 0, no done; byte 1 never written.
- With MEMCTRL_IO_STALL_EN: store len 0 to 0x30000, io_buffer_full=1 for 3 cycles -> mem_wr held 0 for those cycles, then a single write and done the following cycle.
